// File: rtl/uart_fifo_ctrl_param.sv
// uart_fifo_ctrl_param
// Parametrised synchronous FIFO controller for the UART TX/RX paths. Storage
// is an inferred register array of DEPTH words of WIDTH bits. DEPTH need not
// be a power of two, so both pointers wrap explicitly at DEPTH-1.
//
// Parameters:
//   WIDTH      data width in bits
//   DEPTH      number of storage entries (>= 2)
//   ADDR_BITS  pointer width, 2**ADDR_BITS >= DEPTH
//   FWFT       0 = registered read (1-cycle latency), 1 = first-word-fall-through
//
// Ports:
//   clock       system clock, rising edge
//   reset_n     asynchronous active-low reset
//   data_in     write data
//   write_n     write request, active low
//   read_n      read request, active low
//   flush       synchronous flush, active high, overrides read and write
//   err_clr     clears the sticky error flags, active high
//   level_th    threshold for the half flag
//   data_out    read data
//   data_valid  data_out qualifier
//   count       entries occupied, 0..DEPTH
//   full        count == DEPTH
//   empty       count == 0
//   half        count >= level_th
//   overflow    sticky: a write was rejected
//   underflow   sticky: a read was rejected
module uart_fifo_ctrl_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 128,
  parameter int ADDR_BITS = 7,
  parameter int FWFT      = 0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 write_n,
  input  logic                 read_n,
  input  logic                 flush,
  input  logic                 err_clr,
  input  logic [ADDR_BITS:0]   level_th,
  output logic [WIDTH-1:0]     data_out,
  output logic                 data_valid,
  output logic [ADDR_BITS:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 half,
  output logic                 overflow,
  output logic                 underflow
);

  localparam logic [ADDR_BITS:0]   DEPTH_C = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   CNT_ONE = 1;
  localparam logic [ADDR_BITS-1:0] LAST_C  = ADDR_BITS'(DEPTH-1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE = 1;

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic                 rd_acc, wr_acc;

  // Pointer increment modulo DEPTH rather than modulo 2**ADDR_BITS.
  function automatic logic [ADDR_BITS-1:0] ptrInc(input logic [ADDR_BITS-1:0] p);
    return (p == LAST_C) ? '0 : p + PTR_ONE;
  endfunction

  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_C);
  assign half      = (count_q >= level_th);
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  // A read frees a slot in the same cycle, so a write into a full FIFO is
  // still accepted when it is paired with a read. Flush suppresses both.
  always_comb begin
    rd_acc = !flush && !read_n && !empty;
    wr_acc = !flush && !write_n && (!full || rd_acc);
  end

  // Next-state for pointers, occupancy and the sticky error flags. A new
  // error in the same cycle as err_clr wins over the clear.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (rd_acc) rd_ptr_d = ptrInc(rd_ptr_q);
      if (wr_acc) wr_ptr_d = ptrInc(wr_ptr_q);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (!flush && !write_n && !wr_acc) ovf_d = 1'b1;
    if (!flush && !read_n && !rd_acc)  unf_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage has no reset so it maps onto plain register/RAM resources.
  always_ff @(posedge clock) begin
    if (wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is always presented; valid whenever something is stored.
      assign data_out   = mem_q[rd_ptr_q];
      assign data_valid = !empty;
    end else begin : g_reg
      logic [WIDTH-1:0] dout_q;
      logic             dv_q;

      // Registered read: the head word is captured on the accepting edge and
      // qualified for exactly the following cycle. Nonblocking semantics mean
      // a simultaneous write to the same slot (full FIFO) returns the old word.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          dout_q <= '0;
          dv_q   <= 1'b0;
        end else begin
          dv_q <= rd_acc;
          if (rd_acc) dout_q <= mem_q[rd_ptr_q];
        end
      end

      assign data_out   = dout_q;
      assign data_valid = dv_q;
    end
  endgenerate

endmodule

// File: tb/tb_uart_fifo_ctrl_param.sv
// tb_uart_fifo_ctrl_param
// Drives three FIFO instances from one shared stimulus stream:
//   lane 0: DEPTH=4, registered read
//   lane 1: DEPTH=5, registered read (non-power-of-two wrap)
//   lane 2: DEPTH=4, first-word-fall-through
// Each lane keeps a queue-based reference and compares every cycle; a set of
// hand-computed expectations pins the directed scenarios.
module tb_uart_fifo_ctrl_param;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] dataIn = 8'h00;
  logic       write_n = 1'b1;
  logic       read_n = 1'b1;
  logic       flush = 1'b0;
  logic       errClr = 1'b0;
  logic [3:0] levelTh = 4'd3;

  int totalChecks = 0;
  int badChecks = 0;

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalChecks++;
    if (act !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs (w/r active high here) and return just after
  // the edge that consumed them.
  task automatic applyStimulus(input logic w, input logic r, input logic [7:0] d,
                               input logic f, input logic c);
    @(negedge clock);
    write_n = !w;
    read_n  = !r;
    dataIn  = d;
    flush   = f;
    errClr  = c;
    @(posedge clock);
    #2;
  endtask

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int DEP = (g == 1) ? 5 : 4;
    localparam int AB  = (g == 1) ? 3 : 2;
    localparam int FW  = (g == 2) ? 1 : 0;

    logic [7:0]  dOut;
    logic        dValid;
    logic [AB:0] cnt;
    logic [AB:0] th;
    logic        isFull, isEmpty, isHalf, ovf, unf;

    assign th = levelTh[AB:0];

    uart_fifo_ctrl_param #(
      .WIDTH(8), .DEPTH(DEP), .ADDR_BITS(AB), .FWFT(FW)
    ) dut (
      .clock(clock), .reset_n(reset_n), .data_in(dataIn),
      .write_n(write_n), .read_n(read_n), .flush(flush), .err_clr(errClr),
      .level_th(th), .data_out(dOut), .data_valid(dValid), .count(cnt),
      .full(isFull), .empty(isEmpty), .half(isHalf),
      .overflow(ovf), .underflow(unf)
    );

    // Reference: a queue of stored words plus the registered-read output.
    logic [7:0] q[$];
    logic [7:0] mOut = 8'h00;
    logic       mValid = 1'b0;
    logic       mOvf = 1'b0;
    logic       mUnf = 1'b0;
    bit         mRd, mWr;

    initial forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        q.delete();
        mOut = 8'h00;
        mValid = 1'b0;
        mOvf = 1'b0;
        mUnf = 1'b0;
      end else if (flush) begin
        q.delete();
        mValid = 1'b0;
        if (errClr) begin
          mOvf = 1'b0;
          mUnf = 1'b0;
        end
      end else begin
        mRd = !read_n && (q.size() > 0);
        mWr = !write_n && ((q.size() < DEP) || mRd);
        mValid = mRd && (FW == 0);
        if (mRd && FW == 0) mOut = q[0];
        if (mRd) void'(q.pop_front());
        if (mWr) q.push_back(dataIn);
        if (errClr) begin
          mOvf = 1'b0;
          mUnf = 1'b0;
        end
        if (!write_n && !mWr) mOvf = 1'b1;
        if (!read_n && !mRd) mUnf = 1'b1;
      end
    end

    initial forever begin
      @(posedge clock);
      #1;
      if (reset_n) begin
        checkOutput($sformatf("lane%0d count", g), 32'(cnt), 32'(q.size()));
        checkOutput($sformatf("lane%0d full", g), 32'(isFull), 32'(q.size() == DEP));
        checkOutput($sformatf("lane%0d empty", g), 32'(isEmpty), 32'(q.size() == 0));
        checkOutput($sformatf("lane%0d half", g), 32'(isHalf), 32'(q.size() >= int'(th)));
        checkOutput($sformatf("lane%0d overflow", g), 32'(ovf), 32'(mOvf));
        checkOutput($sformatf("lane%0d underflow", g), 32'(unf), 32'(mUnf));
        checkOutput($sformatf("lane%0d data_valid", g), 32'(dValid),
                    (FW != 0) ? 32'(q.size() > 0) : 32'(mValid));
        if (FW == 0 || q.size() > 0)
          checkOutput($sformatf("lane%0d data_out", g), 32'(dOut),
                      (FW != 0) ? 32'(q[0]) : 32'(mOut));
      end
    end
  end

  initial begin
    repeat (2) @(negedge clock);
    checkOutput("reset count", 32'(lane[0].cnt), 32'd0);
    checkOutput("reset empty", 32'(lane[0].isEmpty), 32'd1);
    checkOutput("reset full", 32'(lane[0].isFull), 32'd0);
    checkOutput("reset half", 32'(lane[0].isHalf), 32'd0);
    checkOutput("reset valid", 32'(lane[0].dValid), 32'd0);
    checkOutput("reset dout", 32'(lane[0].dOut), 32'd0);
    reset_n = 1'b1;

    // Fill to full; half rises on the third write edge.
    applyStimulus(1, 0, 8'h11, 0, 0);
    applyStimulus(1, 0, 8'h22, 0, 0);
    checkOutput("half before 3rd", 32'(lane[0].isHalf), 32'd0);
    applyStimulus(1, 0, 8'h33, 0, 0);
    checkOutput("half at 3rd", 32'(lane[0].isHalf), 32'd1);
    applyStimulus(1, 0, 8'h44, 0, 0);
    checkOutput("count full", 32'(lane[0].cnt), 32'd4);
    checkOutput("full flag", 32'(lane[0].isFull), 32'd1);
    checkOutput("fwft head", 32'(lane[2].dOut), 32'h11);
    applyStimulus(1, 0, 8'h55, 0, 0);
    checkOutput("overflow set", 32'(lane[0].ovf), 32'd1);
    checkOutput("count after ovf", 32'(lane[0].cnt), 32'd4);
    checkOutput("d5 full", 32'(lane[1].isFull), 32'd1);
    applyStimulus(0, 0, 8'h00, 0, 1);
    checkOutput("overflow cleared", 32'(lane[0].ovf), 32'd0);

    // Read and write together while full: both accepted.
    applyStimulus(1, 1, 8'hAA, 0, 0);
    checkOutput("rw count", 32'(lane[0].cnt), 32'd4);
    checkOutput("rw no ovf", 32'(lane[0].ovf), 32'd0);
    checkOutput("rw dout", 32'(lane[0].dOut), 32'h11);
    checkOutput("rw valid", 32'(lane[0].dValid), 32'd1);
    applyStimulus(0, 1, 8'h00, 0, 0);
    checkOutput("drain1", 32'(lane[0].dOut), 32'h22);
    checkOutput("half at 3", 32'(lane[0].isHalf), 32'd1);
    applyStimulus(0, 1, 8'h00, 0, 0);
    checkOutput("drain2", 32'(lane[0].dOut), 32'h33);
    checkOutput("half falls", 32'(lane[0].isHalf), 32'd0);
    applyStimulus(0, 1, 8'h00, 0, 0);
    checkOutput("drain3", 32'(lane[0].dOut), 32'h44);
    applyStimulus(0, 1, 8'h00, 0, 0);
    checkOutput("drain4", 32'(lane[0].dOut), 32'hAA);
    checkOutput("drained empty", 32'(lane[0].isEmpty), 32'd1);
    applyStimulus(0, 0, 8'h00, 0, 0);
    checkOutput("valid one cycle", 32'(lane[0].dValid), 32'd0);

    // Underflow and its clear; a simultaneous new error beats the clear.
    applyStimulus(0, 1, 8'h00, 0, 0);
    checkOutput("underflow set", 32'(lane[0].unf), 32'd1);
    checkOutput("underflow valid", 32'(lane[0].dValid), 32'd0);
    checkOutput("underflow dout hold", 32'(lane[0].dOut), 32'hAA);
    applyStimulus(0, 0, 8'h00, 0, 1);
    checkOutput("underflow cleared", 32'(lane[0].unf), 32'd0);
    applyStimulus(0, 1, 8'h00, 0, 1);
    checkOutput("set beats clear", 32'(lane[0].unf), 32'd1);
    applyStimulus(0, 0, 8'h00, 0, 1);

    // Flush overrides a concurrent read and write and sets no errors.
    applyStimulus(1, 0, 8'h01, 0, 0);
    applyStimulus(1, 0, 8'h02, 0, 0);
    applyStimulus(1, 0, 8'h03, 0, 0);
    checkOutput("pre-flush count", 32'(lane[0].cnt), 32'd3);
    applyStimulus(1, 1, 8'h77, 1, 0);
    checkOutput("flush count", 32'(lane[0].cnt), 32'd0);
    checkOutput("flush empty", 32'(lane[0].isEmpty), 32'd1);
    checkOutput("flush no ovf", 32'(lane[0].ovf), 32'd0);
    checkOutput("flush no unf", 32'(lane[0].unf), 32'd0);

    // First-word-fall-through visibility.
    applyStimulus(1, 0, 8'h5A, 0, 0);
    checkOutput("fwft valid", 32'(lane[2].dValid), 32'd1);
    checkOutput("fwft dout", 32'(lane[2].dOut), 32'h5A);
    applyStimulus(0, 1, 8'h00, 0, 0);
    checkOutput("fwft popped", 32'(lane[2].dValid), 32'd0);
    checkOutput("fwft empty", 32'(lane[2].isEmpty), 32'd1);

    // Write/read pairs wrap the DEPTH=5 pointers twice.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 0, 8'(i), 0, 0);
      applyStimulus(0, 1, 8'h00, 0, 0);
      checkOutput($sformatf("wrap pair %0d", i), 32'(lane[1].dOut), 32'(i));
    end

    // Asynchronous reset between edges.
    applyStimulus(0, 1, 8'h00, 0, 0);
    applyStimulus(1, 0, 8'h10, 0, 0);
    applyStimulus(1, 0, 8'h20, 0, 0);
    applyStimulus(0, 1, 8'h00, 0, 0);
    @(negedge clock);
    write_n = 1'b1;
    read_n  = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("async count", 32'(lane[0].cnt), 32'd0);
    checkOutput("async empty", 32'(lane[0].isEmpty), 32'd1);
    checkOutput("async valid", 32'(lane[0].dValid), 32'd0);
    checkOutput("async dout", 32'(lane[0].dOut), 32'd0);
    checkOutput("async unf", 32'(lane[0].unf), 32'd0);
    checkOutput("async fwft valid", 32'(lane[2].dValid), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    applyStimulus(0, 0, 8'h00, 0, 0);
    applyStimulus(0, 0, 8'h00, 0, 0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
